// File: rtl/prenc_rr.sv
// prenc_rr: registered N-way priority encoder with optional round-robin and valid/ack hold
module prenc_rr #(
  parameter int N = 8,
  localparam int W = (N > 2) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic         Mode,
  input  logic         Ack,
  output logic [W-1:0] Y,
  output logic [N-1:0] Grant,
  output logic         Valid,
  output logic         Idle
);
  logic [W-1:0]   r_y, r_ptr;
  logic [N-1:0]   r_grant;
  logic           r_valid;
  logic           w_load, w_ack, w_hit;
  logic [W-1:0]   w_dec, w_start, w_win;
  logic [W:0]     w_p;
  logic [2*N-1:0] w_dbl;
  assign w_ack   = r_valid && Ack;
  assign w_load  = !r_valid || Ack;
  assign w_hit   = |A;
  assign w_dec   = (r_y == '0) ? W'(N - 1) : r_y - 1'b1;
  assign w_start = !Mode ? W'(N - 1) : (w_ack ? w_dec : r_ptr);
  assign w_dbl   = {A, A};
  // Scan from lowest to highest priority so the nearest set bit below the start wins
  always_comb begin
    w_p = '0;
    w_win = '0;
    for (int j = N - 1; j >= 0; j--) begin
      w_p = {1'b0, w_start} + (W+1)'(N - j);
      if (w_dbl[w_p]) w_win = W'(w_p >= (W+1)'(N) ? w_p - (W+1)'(N) : w_p);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_ptr   <= W'(N - 1);
    end else begin
      if (w_ack && Mode) r_ptr <= w_dec;
      if (w_load) begin
        r_valid <= w_hit;
        r_y     <= w_hit ? w_win : '0;
        r_grant <= w_hit ? {{(N-1){1'b0}}, 1'b1} << w_win : '0;
      end
    end
  end
  assign Y     = r_y;
  assign Grant = r_grant;
  assign Valid = r_valid;
  assign Idle  = !r_valid;
endmodule
